// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM states, forwarding encodings and drain default
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  localparam int DRAIN_CYCLES_DEF = 3;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel: EX operand source select, MEM result preferred over WB
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  logic mem_hit, wb_hit;
  assign mem_hit = mem_valid & mem_wr & (mem_rd != 5'd0) & (mem_rd == rs);
  assign wb_hit = wb_valid & wb_wr & (wb_rd != 5'd0) & (wb_rd == rs);
  assign sel = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control plus halt/trap drain FSM and stall counter
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_halt,
  input  logic             i_id_trap,
  input  logic             i_ex_valid,
  input  logic             i_ex_reg_wr_en,
  input  logic             i_ex_dmem_rd_en,
  input  logic [4:0]       i_ex_rd,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic             i_mem_valid,
  input  logic             i_mem_reg_wr_en,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_wb_valid,
  input  logic             i_wb_reg_wr_en,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_ex_redirect,
  input  logic             i_dmem_busy,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_exmem_stall,
  output logic             o_memwb_stall,
  output logic [1:0]       o_fwd_rs1_sel,
  output logic [1:0]       o_fwd_rs2_sel,
  output logic             o_halted,
  output logic             o_trapped,
  output logic [CNT_W-1:0] o_stall_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  state_t state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic trap_q, trap_nx;
  logic halted_s, drain_s, busy, redir, lu, accept, front_stall;
  logic unused_ok;
  assign unused_ok = i_ex_reg_wr_en;
  assign halted_s = state == HALTED;
  assign drain_s = state == DRAIN;
  assign busy = i_dmem_busy & ~halted_s;
  assign redir = i_ex_redirect & ~halted_s;
  assign lu = i_ex_valid & i_ex_dmem_rd_en & (i_ex_rd != 5'd0) & i_id_valid &
              ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) | (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
  assign accept = (state == RUN) & ~busy & ~redir & ~lu & i_id_valid & (i_id_halt | i_id_trap);
  assign front_stall = halted_s | busy | (~redir & (drain_s | lu));
  assign o_pc_stall = front_stall;
  assign o_ifid_stall = front_stall;
  assign o_ifid_flush = redir & ~busy;
  assign o_idex_bubble = halted_s | (~busy & (redir | drain_s | lu));
  assign o_exmem_stall = busy;
  assign o_memwb_stall = busy;
  assign o_halted = halted_s;
  assign o_trapped = halted_s & trap_q;
  hazard_fwd_sel u_fwd_rs1 (
    .rs(i_ex_rs1), .mem_valid(i_mem_valid), .mem_wr(i_mem_reg_wr_en), .mem_rd(i_mem_rd),
    .wb_valid(i_wb_valid), .wb_wr(i_wb_reg_wr_en), .wb_rd(i_wb_rd), .sel(o_fwd_rs1_sel)
  );
  hazard_fwd_sel u_fwd_rs2 (
    .rs(i_ex_rs2), .mem_valid(i_mem_valid), .mem_wr(i_mem_reg_wr_en), .mem_rd(i_mem_rd),
    .wb_valid(i_wb_valid), .wb_wr(i_wb_reg_wr_en), .wb_rd(i_wb_rd), .sel(o_fwd_rs2_sel)
  );
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    trap_nx = trap_q;
    if (accept) begin
      state_nx = DRAIN;
      cnt_nx = DW'(DRAIN_CYCLES);
      trap_nx = i_id_trap;
    end else if (drain_s & ~busy & redir) begin
      state_nx = RUN;
      cnt_nx = '0;
      trap_nx = 1'b0;
    end else if (drain_s & ~busy) begin
      cnt_nx = (cnt != '0) ? cnt - DW'(1) : cnt;
      state_nx = (cnt <= DW'(1)) ? HALTED : DRAIN;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= RUN;
      cnt <= '0;
      trap_q <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      trap_q <= trap_nx;
      if (o_pc_stall & ~halted_s & ~&o_stall_cnt) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end
endmodule
